// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// rtl/hazard_scoreboard_ctrl_pkg.sv - shared encodings, entry types and compare helpers for the hazard controller
package hazard_scoreboard_ctrl_pkg;

    localparam logic [1:0] FWD_GRF   = 2'd0;
    localparam logic [1:0] FWD_W     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;

    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // E-stage shadow entry; is_div travels with md so the busy counter knows what to load
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md;
        logic       is_div;
    } e_entry_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } m_entry_t;

    // M has priority over W; M only forwards once its result is actually in ALUOutput_M
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew,
        input logic [4:0] w_dst
    );
        logic [1:0] sel;
        sel = FWD_GRF;
        if (r != 5'd0 && r == m_dst && m_tnew == 2'd0) begin
            sel = FWD_M;
        end else if (r != 5'd0 && r == w_dst) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    // A producer still too far from its result for the consumer's deadline forces a stall
    function automatic logic data_hazard(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        logic hz;
        hz = 1'b0;
        if (tuse != TUSE_NONE && r != 5'd0) begin
            if (r == e_dst && e_tnew > tuse) hz = 1'b1;
            if (r == m_dst && m_tnew > tuse) hz = 1'b1;
        end
        return hz;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_md_busy_counter.sv
// rtl/hazard_scoreboard_ctrl_md_busy_counter.sv - busy counter for the multi-cycle mult/div unit
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic Load,
    input  logic IsDiv,
    output logic Busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] count;

    // Load has priority over the decrement; the count parks at zero once the unit is done
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            count <= '0;
        end else if (Load) begin
            count <= IsDiv ? DIV_LOAD : MULT_LOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign Busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - decode-stage stall/forward controller with E/M/W shadow scoreboard
module hazard_scoreboard_ctrl
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [4:0] RS_D,
    input  logic [4:0] RT_D,
    input  logic [1:0] TuseRS_D,
    input  logic [1:0] TuseRT_D,
    input  logic [4:0] Dst_D,
    input  logic [1:0] Tnew_D,
    input  logic       MDStart_D,
    input  logic       MDIsDiv_D,
    input  logic       MDUse_D,
    output logic       Stall,
    output logic [1:0] ForwardRSD,
    output logic [1:0] ForwardRTD,
    output logic [1:0] ForwardRSE,
    output logic [1:0] ForwardRTE,
    output logic       MDBusy
);

    e_entry_t   e_q;
    m_entry_t   m_q;
    logic [4:0] w_dst_q;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    // Forward selects and stall decision are purely combinational from the scoreboard
    always_comb begin
        ForwardRSD = fwd_sel(RS_D,   m_q.dst, m_q.tnew, w_dst_q);
        ForwardRTD = fwd_sel(RT_D,   m_q.dst, m_q.tnew, w_dst_q);
        ForwardRSE = fwd_sel(e_q.rs, m_q.dst, m_q.tnew, w_dst_q);
        ForwardRTE = fwd_sel(e_q.rt, m_q.dst, m_q.tnew, w_dst_q);
        stall_rs   = data_hazard(RS_D, TuseRS_D, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew);
        stall_rt   = data_hazard(RT_D, TuseRT_D, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew);
        stall_md   = (MDStart_D || MDUse_D) && (MDBusy || e_q.md);
        Stall      = stall_rs || stall_rt || stall_md;
    end

    // Shadow pipeline advance; a stalled D stage injects an all-zero bubble into E
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_dst_q <= '0;
        end else begin
            m_q.dst  <= e_q.dst;
            m_q.tnew <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
            w_dst_q  <= m_q.dst;
            if (Stall) begin
                e_q <= '0;
            end else begin
                e_q.dst    <= Dst_D;
                e_q.tnew   <= Tnew_D;
                e_q.rs     <= RS_D;
                e_q.rt     <= RT_D;
                e_q.md     <= MDStart_D;
                e_q.is_div <= MDStart_D && MDIsDiv_D;
            end
        end
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .CLK   (CLK),
        .Reset (Reset),
        .Load  (e_q.md),
        .IsDiv (e_q.is_div),
        .Busy  (MDBusy)
    );

endmodule
